// File: rtl/handshake_constant_fork_pkg.sv
// Shared handshake definitions: counter width and constant fitting helper.
// Used by handshake_constant_fork; see HANDSHAKE_CONST_FORK_PERF_CNT_EN there.
package handshake_constant_fork_pkg;

    localparam int PERF_CNT_WIDTH  = 32;
    localparam int CONST_MAX_WIDTH = 256;

    // Zero-extends or truncates a constant to the requested width.
    function automatic logic [CONST_MAX_WIDTH-1:0] fit_const(
        input logic [CONST_MAX_WIDTH-1:0] value,
        input int                         width
    );
        logic [CONST_MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < CONST_MAX_WIDTH; i++) begin
            if (i < width) r[i] = value[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_fork_slot.sv
// One eager-fork output slot: remembers whether this channel already took
// the copy belonging to the current control token.
module handshake_fork_slot (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic ready,
    input  logic retire,
    output logic valid_out,
    output logic done
);

    logic sent_q;
    logic sent_d;

    assign valid_out = valid & ~sent_q;
    assign done      = sent_q | (valid_out & ready);

    always_comb begin
        sent_d = sent_q;
        if (retire) begin
            sent_d = 1'b0;
        end else if (valid) begin
            sent_d = done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/handshake_constant_fork.sv
// Constant source with built-in eager fork: one copy per channel per token.
// Optional transfer counter under HANDSHAKE_CONST_FORK_PERF_CNT_EN.
module handshake_constant_fork
    import handshake_constant_fork_pkg::*;
#(
    parameter int                         DATA_WIDTH = 32,
    parameter logic [CONST_MAX_WIDTH-1:0] VALUE      = '0,
    parameter int                         NUM_OUTS   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_valid,
    output logic                      ctrl_ready,
    output logic [DATA_WIDTH-1:0]     outs,
    output logic [NUM_OUTS-1:0]       outs_valid,
    input  logic [NUM_OUTS-1:0]       outs_ready
`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
   ,output logic [PERF_CNT_WIDTH-1:0] perf_count
`endif
);

    localparam logic [CONST_MAX_WIDTH-1:0] CONST_FIT = fit_const(VALUE, DATA_WIDTH);

    logic [NUM_OUTS-1:0] done;
    logic                retire;

    assign outs       = CONST_FIT[DATA_WIDTH-1:0];
    assign ctrl_ready = &done;
    assign retire     = ctrl_valid & ctrl_ready;

    for (genvar g = 0; g < NUM_OUTS; g++) begin : g_slot
        handshake_fork_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .valid     (ctrl_valid),
            .ready     (outs_ready[g]),
            .retire    (retire),
            .valid_out (outs_valid[g]),
            .done      (done[g])
        );
    end

`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] perf_q;
    logic [PERF_CNT_WIDTH-1:0] perf_d;

    // Free-running wrap; no saturation.
    always_comb begin
        perf_d = perf_q + PERF_CNT_WIDTH'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_handshake_constant_fork.sv
// Self-checking bench for handshake_constant_fork (2- and 3-channel builds).
module tb_handshake_constant_fork;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv2, cv3;
    logic [1:0] rdy2;
    logic [2:0] rdy3;
    logic       cr2, cr3;
    logic [9:0] outs2;
    logic [7:0] outs3;
    logic [1:0] ov2;
    logic [2:0] ov3;
`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
    logic [31:0] perf2, perf3;
`endif

    always #5 clk = ~clk;

    handshake_constant_fork #(.DATA_WIDTH(10), .VALUE('h3B6), .NUM_OUTS(2)) dut (
        .clk(clk), .rst(rst), .ctrl_valid(cv2), .ctrl_ready(cr2),
        .outs(outs2), .outs_valid(ov2), .outs_ready(rdy2)
`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
       ,.perf_count(perf2)
`endif
    );

    handshake_constant_fork #(.DATA_WIDTH(8), .VALUE('h1A5), .NUM_OUTS(3)) dut3 (
        .clk(clk), .rst(rst), .ctrl_valid(cv3), .ctrl_ready(cr3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(rdy3)
`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
       ,.perf_count(perf3)
`endif
    );

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] rdy;
        logic [1:0] ov;
        logic       cr;
    } vec_t;

    typedef struct {
        logic [1:0] ov;
        logic       cr;
        int         step;
    } exp_t;

    vec_t vecs[18];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    int   copies[2];
    int   copies3;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, step, act, req);
        end
    endtask

    task automatic step3(input logic [2:0] r, input logic [2:0] eov, input logic ecr);
        @(negedge clk);
        cv3  = 1'b1;
        rdy3 = r;
        #1;
        check("ov3", 32'(ov3), 32'(eov));
        check("cr3", 32'(cr3), 32'(ecr));
        copies3 += $countones(ov3 & rdy3);
        step++;
    endtask

    initial begin
        exp_t e;
        // rst, cv, rdy -> ov, cr ; state carries from row to row
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'b11, 2'b11, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 2'b11, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 2'b10, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b11, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 2'b11, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b01, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 2'b11, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'b00, 2'b11, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

        rst = 1'b1; cv2 = 1'b0; cv3 = 1'b0; rdy2 = 2'b00; rdy3 = 3'b000;
        copies[0] = 0; copies[1] = 0; copies3 = 0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            step = i;
            rst  = vecs[i].rst;
            cv2  = vecs[i].cv;
            rdy2 = vecs[i].rdy;
            sbq.push_back('{vecs[i].ov, vecs[i].cr, i});
            #1;
            e = sbq.pop_front();
            check("outs",       32'(outs2), 32'h3B6);
            check("outs_valid", 32'(ov2),   32'(e.ov));
            check("ctrl_ready", 32'(cr2),   32'(e.cr));
            if (rst) begin
                copies[0] = 0; copies[1] = 0;
            end else begin
                for (int c = 0; c < 2; c++) copies[c] += int'(ov2[c] & rdy2[c]);
                if (cv2 && cr2) begin
                    check("copies_ch0", 32'(copies[0]), 32'd1);
                    check("copies_ch1", 32'(copies[1]), 32'd1);
                    copies[0] = 0; copies[1] = 0;
                end
            end
        end

        // 3-channel staggered readiness
        @(negedge clk);
        rst = 1'b1; cv2 = 1'b0; rdy2 = 2'b00; cv3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("outs3", 32'(outs3), 32'hA5);
        copies3 = 0;
        step3(3'b001, 3'b111, 1'b0);
        step3(3'b010, 3'b110, 1'b0);
        step3(3'b100, 3'b100, 1'b1);
        check("copies3", 32'(copies3), 32'd3);
        step3(3'b000, 3'b111, 1'b0);
        step3(3'b111, 3'b111, 1'b1);
        @(negedge clk);
        cv3 = 1'b0; rdy3 = 3'b000;

`ifdef HANDSHAKE_CONST_FORK_PERF_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("perf_reset", perf2, 32'd0);
        cv2 = 1'b1; rdy2 = 2'b11;
        repeat (10) @(negedge clk);
        cv2 = 1'b0;
        #1;
        check("perf_10", perf2, 32'd10);
        @(negedge clk);
        force dut.perf_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_q;
        cv2 = 1'b1; rdy2 = 2'b11;
        @(negedge clk);
        cv2 = 1'b0;
        #1;
        check("perf_wrap", perf2, 32'd0);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_constant_fork.md
# handshake_constant_fork

Dataflow constant source with a built-in eager fork. Each control token on `ctrl` produces one copy of a compile-time constant on each of `NUM_OUTS` independent output channels. Copies may be accepted by consumers in any order and on any cycle. The block sits where the dataflow compiler places a constant that feeds several consumers, and it removes the separate constant-plus-fork pair.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the constant and of every output data bus.
- `VALUE`, default 0: the constant. It is zero-extended or truncated to `DATA_WIDTH`.
- `NUM_OUTS`, default 2: number of output channels. The legal minimum is 1.

Ports:
- `clk`, input, width 1: the single clock; all state updates on its rising edge.
- `rst`, input, width 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `ctrl_valid`, input, width 1: a control token is present.
- `ctrl_ready`, output, width 1: the control token is consumed this cycle.
- `outs`, output, width `DATA_WIDTH`: the constant, shared by all channels.
- `outs_valid`, output, width `NUM_OUTS`: per-channel valid.
- `outs_ready`, input, width `NUM_OUTS`: per-channel ready.
- `perf_count`, output, width 32: number of completed control transfers. Present only under the macro in Configuration.

## Operation
- Each channel `i` has one state bit, `sent[i]`, meaning "the copy for the current token has already been taken".
- Combinational outputs:
  - `outs` = `VALUE[DATA_WIDTH-1:0]`, constant in every cycle including reset.
  - `outs_valid[i]` = `ctrl_valid & ~sent[i]`.
  - `done[i]` = `sent[i] | (outs_valid[i] & outs_ready[i])`.
  - `ctrl_ready` = AND over all `i` of `done[i]`.
- Sequential update, when `rst` is 0:
  - If `ctrl_valid & ctrl_ready`: every `sent[i]` is cleared to 0, because the token is retired.
  - Else if `ctrl_valid`: `sent[i]` takes the value `done[i]`. Partial progress is retained.
  - Else: `sent` holds its value.
- Protocol:
  - Upstream keeps `ctrl_valid` high until `ctrl_ready`.
  - `ctrl_valid` dropping mid-token is a protocol violation. In that case `sent` holds, and the remaining copies are emitted when valid returns.
- A channel that has taken its copy sees `outs_valid[i]` = 0 until the next token. No channel ever receives two copies of one token.
- `NUM_OUTS` = 1 degenerates to `ctrl_ready` = `outs_ready` and `outs_valid` = `ctrl_valid`, with no stored state in effect.
- Reset values:
  - `sent` = 0.
  - `outs_valid` then follows `ctrl_valid` directly.
  - `ctrl_ready` is combinational, so it may be 1 during reset if every `outs_ready` is 1.
  - `perf_count` = 0.
- Reset asserted mid-token: all `sent` bits clear on that edge and `perf_count` is zeroed. Any partial emission is forgotten, and all channels become valid again for the pending token.

## Timing
- Latency is zero: `outs_valid` asserts in the same cycle as `ctrl_valid`.
- The `ctrl_ready` path is combinational from `outs_ready` to `ctrl_ready`. There is no register on the data or valid path.
- Throughput: one token per cycle when all `outs_ready` are 1.
- With a consumer that stalls, the token retires in the cycle its last channel accepts.
- Back-to-back tokens: the `sent` clear on the retire edge makes all channels valid for the next token in the following cycle.

## Configuration
- Macro `HANDSHAKE_CONST_FORK_PERF_CNT_EN`.
- Defined:
  - `perf_count` exists.
  - It increments by 1 on every cycle with `ctrl_valid & ctrl_ready & ~rst`.
  - It wraps from 0xFFFFFFFF to 0 and has no saturation.
  - It clears synchronously on `rst`.
- Undefined: the port and the counter register are absent. All other behaviour is identical.

## Structure
- Shared handshake package holds the `PERF_CNT_WIDTH` = 32 constant and the helper function that truncates or extends `VALUE` to `DATA_WIDTH`.
- One sub-module, `handshake_fork_slot`, instantiated `NUM_OUTS` times. It holds one `sent` bit, with inputs `valid`, `ready`, `retire` and outputs `valid_out`, `done`.
- The top level contains the AND-reduction, the constant driver, and the optional counter.

## Test plan
- Reset, then `ctrl_valid`=1 and `outs_ready`=2'b11 (`NUM_OUTS`=2, `VALUE`=0x3B6, `DATA_WIDTH`=10) -> same cycle `outs`=0x3B6, `outs_valid`=2'b11, `ctrl_ready`=1, `sent` stays 00.
- `ctrl_valid`=1, `outs_ready`=01 for 3 cycles then 10 -> `outs_valid` is 11, then 10, 10, 10; `ctrl_ready`=1 only in cycle 4; channel 0 accepts exactly once.
- `NUM_OUTS`=3, readiness staggered one channel per cycle (001, 010, 100) -> `ctrl_ready` pulses in cycle 3 only; 3 copies total; next token sees `outs_valid`=111.
- `rst` asserted after channel 0 took its copy, `ctrl_valid` still 1 -> the next cycle `outs_valid`=both bits set; channel 0 receives the token again.
- Macro defined, 10 back-to-back tokens with all ready -> `perf_count`=10. Counter preloaded to 0xFFFFFFFF plus one transfer -> 0.
